// File: rtl/vx_gpr_req_seq.sv
// GPR read-request sequencer: latches one request per warp instruction and
// issues its used sources as beats over NUM_PORTS read ports. Optional macro: GPR_ZERO_SKIP_EN.
module vx_gpr_req_seq #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 32,
  parameter int NUM_SRCS  = 3,
  parameter int NUM_PORTS = 2,
  localparam int NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NR_BITS  = $clog2(NUM_REGS),
  localparam int SRC_BITS = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NW_BITS-1:0]            req_wid,
  input  logic [NUM_SRCS*NR_BITS-1:0]   req_rs,
  input  logic [NUM_SRCS-1:0]           req_used,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [NW_BITS-1:0]            rd_wid,
  output logic [NUM_PORTS-1:0]          rd_port_en,
  output logic [NUM_PORTS*NR_BITS-1:0]  rd_addr,
  output logic [NUM_PORTS*SRC_BITS-1:0] rd_src,
  output logic                          rd_last
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                           state_q, state_d;
  logic [NW_BITS-1:0]               wid_q, wid_d;
  logic [NUM_SRCS-1:0][NR_BITS-1:0] rs_q, rs_d, req_rs_a;
  logic [NUM_SRCS-1:0]              pending_q, pending_d, used_m, issued;
  logic [NUM_PORTS-1:0]             en_c;
  logic [NUM_PORTS-1:0][NR_BITS-1:0]  addr_c;
  logic [NUM_PORTS-1:0][SRC_BITS-1:0] src_c;
  logic                             last_c, beat_fire, req_fire;

  assign req_rs_a = req_rs;

  // Sources that actually need an RF read at accept time.
  always_comb begin
    used_m = req_used;
`ifdef GPR_ZERO_SKIP_EN
    for (int i = 0; i < NUM_SRCS; i++)
      if (req_rs_a[i] == '0) used_m[i] = 1'b0;
`endif
  end

  // Pack the lowest NUM_PORTS pending sources onto ports 0..k-1 in ascending order.
  always_comb begin
    int rank;
    rank   = 0;
    en_c   = '0;
    addr_c = '0;
    src_c  = '0;
    issued = '0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      if (pending_q[i]) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (rank == p) begin
            en_c[p]   = 1'b1;
            addr_c[p] = rs_q[i];
            src_c[p]  = SRC_BITS'(i);
            issued[i] = 1'b1;
          end
        end
        rank = rank + 1;
      end
    end
  end

  assign last_c     = (state_q == ISSUE) && ($countones(pending_q) <= NUM_PORTS);
  assign rd_valid   = (state_q == ISSUE);
  assign rd_wid     = wid_q;
  assign rd_port_en = en_c;
  assign rd_addr    = addr_c;
  assign rd_src     = src_c;
  assign rd_last    = last_c;

  assign beat_fire = rd_valid && rd_ready;
  assign req_ready = (state_q == IDLE) || (beat_fire && last_c);
  assign req_fire  = req_valid && req_ready;

  // A request accepted on a last beat overrides the return to IDLE.
  always_comb begin
    state_d   = state_q;
    wid_d     = wid_q;
    rs_d      = rs_q;
    pending_d = pending_q;
    if (beat_fire) begin
      pending_d = pending_q & ~issued;
      if (last_c) state_d = IDLE;
    end
    if (req_fire) begin
      state_d   = ISSUE;
      wid_d     = req_wid;
      rs_d      = req_rs_a;
      pending_d = used_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wid_q     <= '0;
      rs_q      <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      wid_q     <= wid_d;
      rs_q      <= rs_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_vx_gpr_req_seq.sv
// Scoreboard bench for vx_gpr_req_seq: a request-level model chunks used sources
// into port-wide beats; a monitor compares every handshaken beat and checks stall stability.
module tb_vx_gpr_req_seq;
  localparam int NW = 4, NRG = 32, NS = 3, NP = 2;
  localparam int NWB = 2, NRB = 5, SB = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [NWB-1:0] req_wid = '0;
  logic [NS*NRB-1:0] req_rs = '0;
  logic [NS-1:0] req_used = '0;
  logic rd_valid;
  logic rd_ready = 1'b0;
  logic [NWB-1:0] rd_wid;
  logic [NP-1:0] rd_port_en;
  logic [NP*NRB-1:0] rd_addr;
  logic [NP*SB-1:0] rd_src;
  logic rd_last;

  vx_gpr_req_seq #(.NUM_WARPS(NW), .NUM_REGS(NRG), .NUM_SRCS(NS), .NUM_PORTS(NP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wid(req_wid), .req_rs(req_rs), .req_used(req_used),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_wid(rd_wid), .rd_port_en(rd_port_en),
    .rd_addr(rd_addr), .rd_src(rd_src), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NWB-1:0]    wid;
    logic [NP-1:0]     en;
    logic [NP*NRB-1:0] addr;
    logic [NP*SB-1:0]  src;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0, passed = 0, idle_cnt = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: list the sources needing a read, then cut the list into NP-wide beats.
  task automatic push_expect(input logic [NWB-1:0] w, input logic [NS*NRB-1:0] rs,
                             input logic [NS-1:0] used);
    int idx[$];
    int nb;
    beat_t b;
    logic [NRB-1:0] r;
    for (int i = 0; i < NS; i++) begin
      r = rs[i*NRB +: NRB];
`ifdef GPR_ZERO_SKIP_EN
      if (used[i] && r != 0) idx.push_back(i);
`else
      if (used[i]) idx.push_back(i);
`endif
    end
    nb = (idx.size() == 0) ? 1 : (idx.size() + NP - 1) / NP;
    for (int k = 0; k < nb; k++) begin
      b = '0;
      b.wid = w;
      b.last = (k == nb - 1);
      for (int p = 0; p < NP; p++) begin
        if (k*NP + p < idx.size()) begin
          b.en[p] = 1'b1;
          b.addr[p*NRB +: NRB] = rs[idx[k*NP+p]*NRB +: NRB];
          b.src[p*SB +: SB] = SB'(idx[k*NP+p]);
        end
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic send(input logic [NWB-1:0] w, input logic [NS*NRB-1:0] rs,
                      input logic [NS-1:0] used, output int waited);
    waited = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wid = w; req_rs = rs; req_used = used;
    @(negedge clk);
    while (!req_ready && waited < 300) begin @(negedge clk); waited++; end
    chk("req_accept", req_ready, 1);
    push_expect(w, rs, used);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("first_beat_latency", rd_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_valid) && n < 300) begin @(negedge clk); n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare each accepted beat; outputs must hold while stalled.
  initial begin
    beat_t cur, prev, e;
    bit stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        cur = {rd_wid, rd_port_en, rd_addr, rd_src, rd_last};
        if (rd_valid) begin
          if (stalled) chk("stall_hold", cur, prev);
          if (rd_ready) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("beat", cur, e);
            end
            stalled = 1'b0;
          end else begin
            prev = cur;
            stalled = 1'b1;
          end
        end else begin
          idle_cnt++;
          stalled = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) rd_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    int w, idle0;
    logic [NRB-1:0] r0, r1, r2;
    #2;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outs", {rd_port_en, rd_last, rd_wid, rd_addr, rd_src}, 0);
    #10 reset = 1'b1;

    rd_ready = 1'b1;
    send(2'd0, {5'd9, 5'd7, 5'd5}, 3'b111, w);   // two beats
    drain();
    chk("idle_after_t1", {req_ready, rd_valid}, 2'b10);
    send(2'd1, {5'd9, 5'd7, 5'd5}, 3'b010, w);   // single src1
    drain();
    send(2'd2, {5'd9, 5'd7, 5'd5}, 3'b000, w);   // empty completion beat
    drain();

    // stall on first beat
    rd_ready = 1'b0;
    send(2'd3, {5'd9, 5'd7, 5'd5}, 3'b111, w);
    chk("stall_q_depth", exp_q.size(), 2);
    repeat (3) @(negedge clk);
    chk("stall_no_pop", exp_q.size(), 2);
    @(posedge clk); #1 rd_ready = 1'b1;
    drain();

    // back-to-back: second request taken on first's last beat
    send(2'd1, {5'd9, 5'd7, 5'd5}, 3'b111, w);
    idle0 = idle_cnt;
    send(2'd2, {5'd3, 5'd2, 5'd1}, 3'b111, w);
    chk("b2b_no_wait", w, 0);
    chk("b2b_no_bubble", idle_cnt - idle0, 0);
    drain();

    // x0 sources: one beat with zero skip, two without
    send(2'd3, {5'd0, 5'd3, 5'd0}, 3'b111, w);
    drain();

    rand_rdy = 1'b1;
    for (int t = 0; t < 60; t++) begin
      r0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      send(2'($urandom_range(0, 3)), {r2, r1, r0}, 3'($urandom_range(0, 7)), w);
    end
    drain();
    rand_rdy = 1'b0;

    // reset mid-beat drops the request
    @(posedge clk); #1 rd_ready = 1'b0;
    send(2'd1, {5'd9, 5'd7, 5'd5}, 3'b111, w);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_outs", {rd_port_en, rd_last}, 0);
    exp_q.delete();
    #1 reset = 1'b1;
    rd_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", {req_ready, rd_valid}, 2'b10);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
